mem_host_sequencer: RTL

Host-side sequencer for the simple processor's memory images. It accepts load-IRAM, load-DRAM, run and readback commands over valid/ready handshakes. It drives the external IRAM/DRAM write and read strobes with auto-incrementing addresses, and holds processor start until the core reports done. It replaces the hand-timed external loading sequence with a single-clock controller that can be synthesised.

---
 rtl/mem_host_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_host_sequencer.sv
// Host-side loader/runner/readback sequencer for the processor's IRAM and DRAM.
// Define SEQ_CHECKSUM_EN to add the load_sum running checksum output.
module mem_host_sequencer #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int RD_LAT      = 2,
    parameter int RUN_TIMEOUT = 1048576
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_count,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              host_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              iram_we,
    output logic              dram_we,
    output logic              dram_re,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic              proc_start,
    input  logic              proc_done,
    output logic              busy,
    output logic              err
`ifdef SEQ_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] load_sum
`endif
);

    localparam int RUN_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(RUN_TIMEOUT - 1);
    localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
    localparam logic [2:0]        LAT_LAST = 3'(RD_LAT);
    localparam logic [2:0]        LAT_ONE  = 3'd1;
    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_OUT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_inc;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [RUN_W-1:0]  run_cnt_q;
    logic [2:0]        lat_q;
    logic              dram_sel_q;
    logic              iram_we_q;
    logic              dram_we_q;
    logic              err_q;

    logic accept;
    logic beat;
    logic rd_hs;
    logic timeout;
    logic words_left;

    assign idx_inc    = idx_q + A_ONE;
    assign words_left = (idx_q != cnt_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        beat    = 1'b0;
        rd_hs   = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    unique case (cmd_op)
                        2'd0, 2'd1: begin
                            if (cmd_count != '0) begin
                                state_d = S_LOAD;
                            end
                        end
                        2'd2: state_d = S_RUN;
                        default: begin
                            if (cmd_count != '0) begin
                                state_d = S_RD_ISSUE;
                            end
                        end
                    endcase
                end
            end
            S_LOAD: begin
                beat = wr_valid && words_left;
                // All beats taken: this cycle carries the final strobe.
                if (!words_left) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (proc_done) begin
                    state_d = S_IDLE;
                end else if (run_cnt_q == RUN_LAST) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = S_RD_OUT;
                end
            end
            S_RD_OUT: begin
                if (rd_ready) begin
                    rd_hs = 1'b1;
                    if (idx_inc == cnt_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            run_cnt_q  <= '0;
            lat_q      <= '0;
            dram_sel_q <= 1'b0;
            iram_we_q  <= 1'b0;
            dram_we_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            iram_we_q <= 1'b0;
            dram_we_q <= 1'b0;
            if (accept) begin
                base_q     <= cmd_base;
                cnt_q      <= cmd_count;
                idx_q      <= '0;
                dram_sel_q <= cmd_op[0];
                run_cnt_q  <= '0;
                err_q      <= 1'b0;
            end
            if (beat) begin
                addr_q    <= base_q + idx_q;
                wdata_q   <= wr_data;
                iram_we_q <= !dram_sel_q;
                dram_we_q <= dram_sel_q;
                idx_q     <= idx_inc;
            end
            if (state_q == S_RUN) begin
                run_cnt_q <= run_cnt_q + RUN_ONE;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            if (state_q == S_RD_ISSUE) begin
                lat_q <= LAT_ONE;
            end
            if (state_q == S_RD_WAIT) begin
                if (lat_q == LAT_LAST) begin
                    rdata_q <= dram_rdata;
                end else begin
                    lat_q <= lat_q + LAT_ONE;
                end
            end
            if (rd_hs) begin
                idx_q <= idx_inc;
            end
        end
    end

`ifdef SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
        end else if (accept && !cmd_op[1]) begin
            sum_q <= '0;
        end else if (beat) begin
            sum_q <= sum_q + wr_data;
        end
    end

    assign load_sum = sum_q;
`endif

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign wr_ready   = (state_q == S_LOAD) && words_left;
    assign rd_valid   = (state_q == S_RD_OUT);
    assign rd_data    = rdata_q;
    assign host_sel   = (state_q != S_RUN);
    assign proc_start = (state_q == S_RUN);
    assign dram_re    = (state_q == S_RD_ISSUE);
    assign iram_we    = iram_we_q;
    assign dram_we    = dram_we_q;
    assign mem_wdata  = wdata_q;
    assign err        = err_q;
    // Reads present their address combinationally; writes use the beat's latched address.
    assign mem_addr   = (state_q == S_RD_ISSUE) ? (base_q + idx_q) : addr_q;

endmodule
